// File: rtl/decrypt_iter.sv
// Iterative inverse of the 16-nibble Encrypt cipher: one key-expansion step per
// cycle, then one inverse round per cycle, behind valid/ready handshakes.
module decrypt_iter #(
  parameter int NR = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] ciphertext,
  input  logic [63:0] secretKey,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plaintext,
  output logic        busy
);

  localparam int CW = $clog2(NR + 1);

  typedef enum logic [1:0] {IDLE, KEXP, ROUND, DONE} state_t;

  state_t        state, nxt;
  logic [CW-1:0] rnd;
  logic [63:0]   st;
  logic [63:0]   rk [NR+1];
  logic [63:0]   kexp;
  logic [63:0]   round_out;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
    endcase
  endfunction

  function automatic logic [3:0] inv_sbox(input logic [3:0] x);
    case (x)
      4'h0: inv_sbox = 4'h5;  4'h1: inv_sbox = 4'hE;  4'h2: inv_sbox = 4'hF;  4'h3: inv_sbox = 4'h8;
      4'h4: inv_sbox = 4'hC;  4'h5: inv_sbox = 4'h1;  4'h6: inv_sbox = 4'h2;  4'h7: inv_sbox = 4'hD;
      4'h8: inv_sbox = 4'hB;  4'h9: inv_sbox = 4'h4;  4'hA: inv_sbox = 4'h6;  4'hB: inv_sbox = 4'h3;
      4'hC: inv_sbox = 4'h0;  4'hD: inv_sbox = 4'h7;  4'hE: inv_sbox = 4'h9;  default: inv_sbox = 4'hA;
    endcase
  endfunction

  function automatic logic [63:0] inv_sub_nibbles(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) o[4*i +: 4] = inv_sbox(s[4*i +: 4]);
    return o;
  endfunction

  // Nibble (row, col) lives at index 4*col+row; row r was rotated left by r.
  function automatic logic [63:0] inv_shift_rows(input logic [63:0] s);
    logic [63:0] o;
    o = '0;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        o[4*(4*col+row) +: 4] = s[4*(4*((col+4-row)%4)+row) +: 4];
    return o;
  endfunction

  // Each nibble becomes the XOR of the other three in its column: self-inverse.
  function automatic logic [63:0] mix_columns(input logic [63:0] s);
    logic [63:0] o;
    logic [3:0]  t;
    o = '0;
    for (int col = 0; col < 4; col++) begin
      t = s[16*col +: 4] ^ s[16*col+4 +: 4] ^ s[16*col+8 +: 4] ^ s[16*col+12 +: 4];
      for (int row = 0; row < 4; row++) o[16*col+4*row +: 4] = t ^ s[16*col+4*row +: 4];
    end
    return o;
  endfunction

  function automatic logic [63:0] key_expand(input logic [63:0] k, input logic [3:0] r);
    logic [63:0] t;
    t = {k[55:0], k[63:56]};
    t[63:60] = sbox(t[63:60]);
    t[3:0] = t[3:0] ^ r;
    return t;
  endfunction

  assign kexp = key_expand(rk[rnd - 1'b1], 4'(rnd));

  always_comb begin
    round_out = inv_sub_nibbles(inv_shift_rows(st)) ^ rk[rnd - 1'b1];
    if (rnd != CW'(1)) round_out = mix_columns(round_out);
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (in_valid) nxt = KEXP;
      KEXP:    if (rnd == CW'(NR)) nxt = ROUND;
      ROUND:   if (rnd == CW'(1)) nxt = DONE;
      DONE:    if (out_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rnd       <= '0;
      plaintext <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE:  if (in_valid) rnd <= CW'(1);
        KEXP:  if (rnd != CW'(NR)) rnd <= rnd + 1'b1;
        ROUND: if (rnd != CW'(1)) rnd <= rnd - 1'b1;
               else plaintext <= round_out;
        default: ;
      endcase
    end
  end

  // Datapath registers carry no reset; the control state decides when they matter.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid) begin
        st    <= ciphertext;
        rk[0] <= secretKey;
      end
      KEXP: begin
        rk[rnd] <= kexp;
        if (rnd == CW'(NR)) st <= st ^ kexp;
      end
      ROUND: st <= round_out;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_decrypt_iter.sv
// Directed and randomized round-trip bench for decrypt_iter, using an in-bench
// forward Encrypt model to produce ciphertexts.
module tb_decrypt_iter;
  localparam int NR = 2;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [63:0] ciphertext, secretKey, plaintext;
  int          total = 0;
  int          passed = 0;

  decrypt_iter #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ciphertext(ciphertext), .secretKey(secretKey), .out_valid(out_valid),
    .out_ready(out_ready), .plaintext(plaintext), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] f_sb(input logic [3:0] x);
    logic [63:0] t;
    t = 64'h2174_8FE3_DA09_B65C;
    return t[4*int'(x) +: 4];
  endfunction

  function automatic logic [63:0] kx(input logic [63:0] k, input int r);
    logic [63:0] t;
    t = (k << 8) | (k >> 56);
    t[63:60] = f_sb(t[63:60]);
    t[3:0] = t[3:0] ^ 4'(r);
    return t;
  endfunction

  function automatic logic [63:0] enc(input logic [63:0] pt, input logic [63:0] key);
    logic [63:0] k, s;
    logic [3:0]  n [4][4];
    logic [3:0]  m [4][4];
    logic [3:0]  u4;
    k = key;
    s = pt ^ k;
    for (int r = 1; r <= NR; r++) begin
      k = kx(k, r);
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) n[w][c] = f_sb(s[16*c+4*w +: 4]);
      for (int w = 0; w < 4; w++)
        for (int c = 0; c < 4; c++) m[w][c] = n[w][(c+w)%4];
      if (r < NR) begin
        for (int c = 0; c < 4; c++)
          for (int w = 0; w < 4; w++) begin
            u4 = 4'h0;
            for (int j = 0; j < 4; j++) if (j != w) u4 = u4 ^ m[j][c];
            n[w][c] = u4;
          end
      end else begin
        n = m;
      end
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[16*c+4*w +: 4] = n[w][c];
      s = s ^ k;
    end
    return s;
  endfunction

  // Presents one block, waits for accept and then out_valid; lat counts cycles
  // with the accept cycle as cycle 0.
  task automatic run_op(input logic [63:0] pt, input logic [63:0] key, input bit rdy,
                        output logic [63:0] got, output int lat, output bit ok);
    int w;
    ok = 1'b1;
    out_ready = rdy;
    ciphertext = enc(pt, key);
    secretKey = key;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    if (!in_ready) ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!out_valid) ok = 1'b0;
    got = plaintext;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (plaintext !== 64'h0) $display("FAIL reset_plaintext: got %h want 0", plaintext); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_zero();
    logic [63:0] got; int lat; bit ok;
    run_op(64'h0, 64'h0, 1'b1, got, lat, ok);
    total++; if (!ok || lat != 5 || busy !== 1'b1)
      $display("FAIL zero_latency: got %0d (ok=%0b busy=%b) want 5", lat, ok, busy); else passed++;
    total++; if (got !== 64'h0) $display("FAIL zero_plaintext: got %h want 0", got); else passed++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL zero_busy_fall: busy=%b in_ready=%b out_valid=%b want 0/1/0", busy, in_ready, out_valid);
    else passed++;
  endtask

  task automatic test_sweep();
    logic [63:0] pts [20];
    logic [63:0] keys [20];
    logic [63:0] got; int lat; bit ok;
    pts[0] = 64'h1234_5678_9ABC_DEF0; keys[0] = 64'h0F1E_2D3C_4B5A_6978;
    pts[1] = 64'hDEAD_BEEF_CAFE_BABE; keys[1] = 64'h0123_4567_89AB_CDEF;
    pts[2] = 64'hFFFF_FFFF_FFFF_FFFF; keys[2] = 64'h0;
    pts[3] = 64'h7FFF_FFFF_FFFF_FFFF; keys[3] = 64'h8000_0000_0000_0000;
    for (int i = 4; i < 20; i++) begin
      pts[i]  = 64'h9E37_79B9_7F4A_7C15 * 64'(i);
      keys[i] = {pts[i][31:0], pts[i][63:32]} ^ 64'hA5A5_5A5A_C3C3_3C3C;
    end
    for (int i = 0; i < 20; i++) begin
      run_op(pts[i], keys[i], 1'b1, got, lat, ok);
      total++; if (!ok || got !== pts[i])
        $display("FAIL sweep_%0d: got %h (ok=%0b) want %h", i, got, ok, pts[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] pta, pka, ptb, pkb, got; int lat; bit ok, good;
    pta = 64'h0BAD_F00D_1357_9BDF; pka = 64'h2468_ACE0_1122_3344;
    ptb = 64'h5A5A_A5A5_0F0F_F0F0; pkb = 64'hFEDC_BA98_7654_3210;
    run_op(pta, pka, 1'b0, got, lat, ok);
    total++; if (!ok || got !== pta) $display("FAIL bp_first: got %h want %h", got, pta); else passed++;
    in_valid = 1'b1;
    ciphertext = enc(ptb, pkb);
    secretKey = pkb;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || plaintext !== pta || in_ready !== 1'b0)
        $display("FAIL bp_hold_%0d: out_valid=%b plaintext=%h in_ready=%b want 1/%h/0",
                 i, out_valid, plaintext, in_ready, pta);
      else passed++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL bp_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); else passed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    good = out_valid && lat == 5 && plaintext === ptb;
    total++; if (!good)
      $display("FAIL bp_second: plaintext=%h lat=%0d want %h lat 5", plaintext, lat, ptb); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic [63:0] pt, got; int lat; bit ok, seen;
    out_ready = 1'b1;
    ciphertext = enc(64'h1111_2222_3333_4444, 64'h9999_8888_7777_6666);
    secretKey = 64'h9999_8888_7777_6666;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b want 0", busy); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (plaintext !== 64'h0) $display("FAIL rst_mid_plaintext: got %h want 0", plaintext); else passed++;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen) $display("FAIL rst_mid_no_pulse: out_valid seen 1 want 0"); else passed++;
    pt = 64'hC0FF_EE00_1234_ABCD;
    run_op(pt, 64'h5555_5555_5555_5555, 1'b1, got, lat, ok);
    total++; if (!ok || got !== pt) $display("FAIL rst_mid_after: got %h want %h", got, pt); else passed++;
    @(posedge clk); #1;
    run_op(pt, 64'h1, 1'b0, got, lat, ok);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (!ok || out_valid !== 1'b0 || plaintext !== 64'h0 || in_ready !== 1'b1)
      $display("FAIL rst_done: ok=%0b out_valid=%b plaintext=%h in_ready=%b want 1/0/0/1",
               ok, out_valid, plaintext, in_ready);
    else passed++;
  endtask

  task automatic test_stability();
    logic [63:0] pt, key; int lat;
    pt = 64'h8BAD_BEEF_0000_FFFF; key = 64'h3C3C_C3C3_9669_6996;
    out_ready = 1'b1;
    ciphertext = enc(pt, key);
    secretKey = key;
    in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      ciphertext = {$urandom(), $urandom()};
      secretKey = {$urandom(), $urandom()};
      in_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    total++; if (!out_valid || lat != 5 || plaintext !== pt)
      $display("FAIL stability: plaintext=%h lat=%0d want %h lat 5", plaintext, lat, pt); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    localparam int N = 1000;
    logic [63:0] q [$];
    logic [63:0] ppt, pkey, expv;
    int sent, recv, cyc;
    bit acc, hs;
    sent = 0; recv = 0; cyc = 0;
    in_valid = 1'b0;
    ppt = '0;
    while (recv < N && cyc < 30000) begin
      if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        ppt = {$urandom(), $urandom()};
        pkey = {$urandom(), $urandom()};
        ciphertext = enc(ppt, pkey);
        secretKey = pkey;
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && in_ready;
      hs = out_valid && out_ready;
      if (acc) begin q.push_back(ppt); sent++; end
      if (hs) begin
        total++;
        if (q.size() == 0) $display("FAIL b2b_dup: output %h with nothing pending", plaintext);
        else begin
          expv = q.pop_front();
          if (plaintext !== expv) $display("FAIL b2b_%0d: got %h want %h", recv, plaintext, expv);
          else passed++;
        end
        recv++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (sent != N || recv != N || q.size() != 0)
      $display("FAIL b2b_count: sent=%0d recv=%0d pending=%0d want %0d/%0d/0", sent, recv, q.size(), N, N);
    else passed++;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ciphertext = '0; secretKey = '0;
    @(posedge clk); #1;
    test_reset();
    test_zero();
    test_sweep();
    test_backpressure();
    test_reset_midop();
    test_stability();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
